// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet frame packetizer: FSM states, header
// layout constants and byte/dibit helpers.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } eth_state_t;

    localparam int HEADER_BYTES = 4;
    localparam int DIBITS_PER_BYTE = 4;
    localparam logic [15:0] DEFAULT_HEADER_MAGIC = 16'hA55A;

    // Header byte order: magic high, magic low, frame id, packet index.
    function automatic logic [7:0] header_byte(
        input logic [15:0] magic,
        input logic [7:0]  frame_id,
        input logic [7:0]  packet_idx,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = magic[15:8];
            2'd1:    b = magic[7:0];
            2'd2:    b = frame_id;
            default: b = packet_idx;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
        logic [7:0] s;
        s = b >> {idx, 1'b0};
        return s[1:0];
    endfunction

endpackage

// File: rtl/pixel_prefetch_fifo.sv
// Four-entry pixel FIFO fed by a fixed-latency frame buffer read port; tracks
// reads in flight so the issuer never overcommits the storage.
module pixel_prefetch_fifo
#(
    parameter int BRAM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic [7:0] pixel,
    input  logic       pop,
    output logic [7:0] head,
    output logic       can_issue
);

    logic [7:0]          mem [4];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [2:0]          count;
    logic [2:0]          inflight;
    logic [BRAM_LATENCY:0] vld;
    logic                wr;

    // vld[0] marks the cycle the address is on the port; data lands BRAM_LATENCY later.
    assign wr        = vld[BRAM_LATENCY];
    assign head      = mem[rd_ptr];
    assign can_issue = ({1'b0, count} + {1'b0, inflight}) < 4'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld      <= '0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            inflight <= 3'd0;
        end else begin
            vld      <= {vld[BRAM_LATENCY-1:0], issue};
            inflight <= inflight + {2'b0, issue} - {2'b0, wr};
            count    <= count + {2'b0, wr} - {2'b0, pop};
            if (wr) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= pixel;
        end
    end

endmodule

// File: rtl/eth_frame_packetizer.sv
// Cuts a frame from the frame buffer into header-prefixed packets and streams
// them as LSB-first dibits with stall back-pressure and inter-packet gaps.
module eth_frame_packetizer
    import eth_pkg::*;
#(
    parameter int          PIXELS_PER_PACKET = 320,
    parameter int          NUM_PIXELS        = 76800,
    parameter int          IPG_CYCLES        = 48,
    parameter int          BRAM_LATENCY      = 2,
    parameter logic [15:0] HEADER_MAGIC      = DEFAULT_HEADER_MAGIC
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        stall_in,
    input  logic [7:0]  pixel_in,
    output logic [16:0] pixel_addr_out,
    output logic        axiov_out,
    output logic [1:0]  axiod_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output eth_state_t  state_dbg
);

    localparam int          NUM_PACKETS = NUM_PIXELS / PIXELS_PER_PACKET;
    localparam logic [17:0] NUM_PIX_L   = 18'(NUM_PIXELS);
    localparam logic [15:0] LAST_HDR    = 16'(HEADER_BYTES - 1);
    localparam logic [15:0] LAST_PIX    = 16'(PIXELS_PER_PACKET - 1);
    localparam logic [15:0] LAST_GAP    = 16'(IPG_CYCLES - 1);
    localparam logic [15:0] LAST_PKT    = 16'(NUM_PACKETS - 1);
    localparam logic [1:0]  LAST_DIB    = 2'(DIBITS_PER_BYTE - 1);

    eth_state_t  state, state_n;
    logic [1:0]  dib, dib_n;
    logic [15:0] byte_cnt, byte_n;
    logic [15:0] gap_cnt, gap_n;
    logic [15:0] pkt_cnt, pkt_n;
    logic [7:0]  frame_id, fid_n;
    logic [7:0]  tx_byte, txb_n;
    logic        v_n;
    logic [1:0]  d_n;
    logic        done_n;
    logic        accept;
    logic        pop;
    logic [7:0]  hb;
    logic [7:0]  fifo_head;
    logic        can_issue;
    logic        issue;
    logic [17:0] fetch_cnt;

    assign state_dbg = state;
    assign accept    = axiov_out && !stall_in;
    assign issue     = (state != ST_IDLE) && can_issue && (fetch_cnt < NUM_PIX_L);

    pixel_prefetch_fifo #(
        .BRAM_LATENCY(BRAM_LATENCY)
    ) u_fifo (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .issue    (issue),
        .pixel    (pixel_in),
        .pop      (pop),
        .head     (fifo_head),
        .can_issue(can_issue)
    );

    // Prefetch walks the frame linearly; the counter parks at zero while idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_cnt      <= 18'd0;
            pixel_addr_out <= 17'd0;
        end else if (state == ST_IDLE) begin
            fetch_cnt      <= 18'd0;
            pixel_addr_out <= 17'd0;
        end else if (issue) begin
            fetch_cnt      <= fetch_cnt + 18'd1;
            pixel_addr_out <= fetch_cnt[16:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            dib            <= 2'd0;
            byte_cnt       <= 16'd0;
            gap_cnt        <= 16'd0;
            pkt_cnt        <= 16'd0;
            frame_id       <= 8'd0;
            tx_byte        <= 8'd0;
            axiov_out      <= 1'b0;
            axiod_out      <= 2'd0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_n;
            dib            <= dib_n;
            byte_cnt       <= byte_n;
            gap_cnt        <= gap_n;
            pkt_cnt        <= pkt_n;
            frame_id       <= fid_n;
            tx_byte        <= txb_n;
            axiov_out      <= v_n;
            axiod_out      <= d_n;
            busy_out       <= (state_n != ST_IDLE);
            frame_done_out <= done_n;
        end
    end

    // Output registers are loaded with the next dibit so axiod_out/axiov_out
    // hold unchanged on any edge that does not accept.
    always_comb begin
        state_n = state;
        dib_n   = dib;
        byte_n  = byte_cnt;
        gap_n   = gap_cnt;
        pkt_n   = pkt_cnt;
        fid_n   = frame_id;
        txb_n   = tx_byte;
        v_n     = axiov_out;
        d_n     = axiod_out;
        done_n  = 1'b0;
        pop     = 1'b0;
        hb      = 8'd0;
        unique case (state)
            ST_IDLE: begin
                if (start_in) begin
                    state_n = ST_HEADER;
                    pkt_n   = 16'd0;
                    byte_n  = 16'd0;
                    dib_n   = 2'd0;
                    hb      = header_byte(HEADER_MAGIC, frame_id, 8'd0, 2'd0);
                    txb_n   = hb;
                    v_n     = 1'b1;
                    d_n     = dibit_of(hb, 2'd0);
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (dib != LAST_DIB) begin
                        dib_n = dib + 2'd1;
                        d_n   = dibit_of(tx_byte, dib + 2'd1);
                    end else begin
                        dib_n = 2'd0;
                        if (byte_cnt == LAST_HDR) begin
                            state_n = ST_PAYLOAD;
                            byte_n  = 16'd0;
                            pop     = 1'b1;
                            txb_n   = fifo_head;
                            d_n     = dibit_of(fifo_head, 2'd0);
                        end else begin
                            byte_n = byte_cnt + 16'd1;
                            hb     = header_byte(HEADER_MAGIC, frame_id, pkt_cnt[7:0],
                                                 byte_cnt[1:0] + 2'd1);
                            txb_n  = hb;
                            d_n    = dibit_of(hb, 2'd0);
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    if (dib != LAST_DIB) begin
                        dib_n = dib + 2'd1;
                        d_n   = dibit_of(tx_byte, dib + 2'd1);
                    end else begin
                        dib_n = 2'd0;
                        if (byte_cnt == LAST_PIX) begin
                            state_n = ST_GAP;
                            gap_n   = 16'd0;
                            v_n     = 1'b0;
                            d_n     = 2'd0;
                        end else begin
                            byte_n = byte_cnt + 16'd1;
                            pop    = 1'b1;
                            txb_n  = fifo_head;
                            d_n    = dibit_of(fifo_head, 2'd0);
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    if (pkt_cnt == LAST_PKT) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        fid_n   = frame_id + 8'd1;
                    end else begin
                        state_n = ST_HEADER;
                        pkt_n   = pkt_cnt + 16'd1;
                        byte_n  = 16'd0;
                        dib_n   = 2'd0;
                        hb      = header_byte(HEADER_MAGIC, frame_id, pkt_n[7:0], 2'd0);
                        txb_n   = hb;
                        v_n     = 1'b1;
                        d_n     = dibit_of(hb, 2'd0);
                    end
                end else begin
                    gap_n = gap_cnt + 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
